// File: rtl/model_trainer_vector_differentiation_if.sv
// Handshake and data bundle for the vector differentiation engine.
// The master side (trainer/stimulus) drives start, length, shift and elements.
// The slave side (the engine) returns ready, element requests and results.
interface model_trainer_vector_differentiation_if #(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 64
);
    localparam int SHIFT_SIZE = $clog2(DATA_SIZE);

    logic                    START;
    logic [CONTROL_SIZE-1:0] SIZE_IN;
    logic [SHIFT_SIZE-1:0]   SHIFT_IN;
    logic                    DATA_IN_ENABLE;
    logic [DATA_SIZE-1:0]    DATA_IN;
    logic                    READY;
    logic                    DATA_ENABLE;
    logic                    DATA_OUT_ENABLE;
    logic [DATA_SIZE-1:0]    DATA_OUT;

    modport master (
        output START,
        output SIZE_IN,
        output SHIFT_IN,
        output DATA_IN_ENABLE,
        output DATA_IN,
        input  READY,
        input  DATA_ENABLE,
        input  DATA_OUT_ENABLE,
        input  DATA_OUT
    );

    modport slave (
        input  START,
        input  SIZE_IN,
        input  SHIFT_IN,
        input  DATA_IN_ENABLE,
        input  DATA_IN,
        output READY,
        output DATA_ENABLE,
        output DATA_OUT_ENABLE,
        output DATA_OUT
    );
endinterface

// File: rtl/model_trainer_vector_differentiation.sv
// Vector differentiation: y[i] = (x[i] - x[i-1]) >>> shift, with x[-1] = 0.
// Elements are requested one at a time via DATA_ENABLE; each accepted element
// produces one result one cycle later, qualified by DATA_OUT_ENABLE.
// Optional feature: define MODEL_TRAINER_DIFFERENTIATION_SATURATION_EN to clamp
// out-of-range differences instead of wrapping them modulo 2^DATA_SIZE.
module model_trainer_vector_differentiation #(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 64
) (
    input logic CLK,
    input logic RST,
    model_trainer_vector_differentiation_if.slave bus
);
    localparam int SHIFT_SIZE = $clog2(DATA_SIZE);

    localparam logic [1:0] IDLE        = 2'd0;
    localparam logic [1:0] INPUT_STATE = 2'd1;
    localparam logic [1:0] ENDER_STATE = 2'd2;

    logic [1:0]                  state;
    logic [CONTROL_SIZE-1:0]     size_q;
    logic [CONTROL_SIZE-1:0]     index_q;
    logic [SHIFT_SIZE-1:0]       shift_q;
    logic signed [DATA_SIZE-1:0] prev_q;
    logic signed [DATA_SIZE-1:0] data_out_q;
    logic                        data_enable_q;
    logic                        data_out_enable_q;

    logic signed [DATA_SIZE:0]   diff;
    logic signed [DATA_SIZE:0]   diff_shifted;
    logic signed [DATA_SIZE-1:0] result;
    logic                        last_element;

    assign bus.READY           = (state == IDLE);
    assign bus.DATA_ENABLE     = data_enable_q;
    assign bus.DATA_OUT_ENABLE = data_out_enable_q;
    assign bus.DATA_OUT        = data_out_q;

    assign last_element = (index_q == size_q - CONTROL_SIZE'(1));

    // One extra bit keeps the raw difference exact before scaling.
    always_comb begin
        diff         = {bus.DATA_IN[DATA_SIZE-1], bus.DATA_IN} - {prev_q[DATA_SIZE-1], prev_q};
        diff_shifted = diff >>> shift_q;
    end

    // Narrow the scaled difference back to DATA_SIZE bits.
`ifdef MODEL_TRAINER_DIFFERENTIATION_SATURATION_EN
    always_comb begin
        result = diff_shifted[DATA_SIZE-1:0];
        if (diff_shifted[DATA_SIZE] != diff_shifted[DATA_SIZE-1]) begin
            result = diff_shifted[DATA_SIZE] ? {1'b1, {(DATA_SIZE-1){1'b0}}}
                                             : {1'b0, {(DATA_SIZE-1){1'b1}}};
        end
    end
`else
    always_comb begin
        result = DATA_SIZE'(diff_shifted);
    end
`endif

    // Control FSM plus datapath registers; output enables are single-cycle pulses.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state             <= IDLE;
            size_q            <= '0;
            index_q           <= '0;
            shift_q           <= '0;
            prev_q            <= '0;
            data_out_q        <= '0;
            data_enable_q     <= 1'b0;
            data_out_enable_q <= 1'b0;
        end else begin
            data_enable_q     <= 1'b0;
            data_out_enable_q <= 1'b0;
            case (state)
                IDLE: begin
                    // A zero-length request has nothing to do and is dropped.
                    if (bus.START && (bus.SIZE_IN != '0)) begin
                        size_q        <= bus.SIZE_IN;
                        shift_q       <= bus.SHIFT_IN;
                        index_q       <= '0;
                        prev_q        <= '0;
                        data_enable_q <= 1'b1;
                        state         <= INPUT_STATE;
                    end
                end
                INPUT_STATE: begin
                    if (bus.DATA_IN_ENABLE) begin
                        data_out_q        <= result;
                        data_out_enable_q <= 1'b1;
                        prev_q            <= bus.DATA_IN;
                        index_q           <= index_q + CONTROL_SIZE'(1);
                        if (last_element) begin
                            state <= ENDER_STATE;
                        end else begin
                            data_enable_q <= 1'b1;
                        end
                    end
                end
                ENDER_STATE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_model_trainer_vector_differentiation.sv
// Directed test of the vector differentiation engine with hand-computed results.
module tb_model_trainer_vector_differentiation;
    localparam int DATA_SIZE    = 64;
    localparam int CONTROL_SIZE = 64;

    localparam logic signed [63:0] MAXV = 64'sh7fff_ffff_ffff_ffff;
    localparam logic signed [63:0] MINV = 64'sh8000_0000_0000_0000;

    logic CLK;
    logic RST;
    int   n_checks;
    int   n_fail;
    logic signed [63:0] exp_wrap;

    model_trainer_vector_differentiation_if #(
        .DATA_SIZE    (DATA_SIZE),
        .CONTROL_SIZE (CONTROL_SIZE)
    ) bus ();

    model_trainer_vector_differentiation #(
        .DATA_SIZE    (DATA_SIZE),
        .CONTROL_SIZE (CONTROL_SIZE)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Pulse START in IDLE and expect the first element request next cycle.
    task automatic start_run(input logic [63:0] size, input logic [5:0] shift);
        bus.START    = 1'b1;
        bus.SIZE_IN  = size;
        bus.SHIFT_IN = shift;
        tick();
        bus.START = 1'b0;
        check_bit("start_ready", bus.READY, 1'b0);
        check_bit("start_de", bus.DATA_ENABLE, 1'b1);
        check_bit("start_doe", bus.DATA_OUT_ENABLE, 1'b0);
    endtask

    // Present one element for one cycle and check the result one cycle later.
    task automatic send(input logic signed [63:0] x, input logic signed [63:0] y,
                        input logic last);
        bus.DATA_IN_ENABLE = 1'b1;
        bus.DATA_IN        = x;
        tick();
        bus.DATA_IN_ENABLE = 1'b0;
        check_bit("elem_doe", bus.DATA_OUT_ENABLE, 1'b1);
        check("elem_out", bus.DATA_OUT, y);
        check_bit("elem_de", bus.DATA_ENABLE, !last);
        check_bit("elem_ready", bus.READY, 1'b0);
        if (last) begin
            tick();
            check_bit("end_ready", bus.READY, 1'b1);
            check_bit("end_doe", bus.DATA_OUT_ENABLE, 1'b0);
            check_bit("end_de", bus.DATA_ENABLE, 1'b0);
            check("end_hold", bus.DATA_OUT, y);
        end
    endtask

    initial begin
        n_checks           = 0;
        n_fail             = 0;
        RST                = 1'b0;
        bus.START          = 1'b0;
        bus.SIZE_IN        = '0;
        bus.SHIFT_IN       = '0;
        bus.DATA_IN_ENABLE = 1'b0;
        bus.DATA_IN        = '0;
        #1;
        check_bit("rst_ready", bus.READY, 1'b1);
        check_bit("rst_de", bus.DATA_ENABLE, 1'b0);
        check_bit("rst_doe", bus.DATA_OUT_ENABLE, 1'b0);
        check("rst_out", bus.DATA_OUT, 64'sd0);
        tick();
        tick();
        RST = 1'b1;
        tick();

        // Elements offered while idle are ignored.
        bus.DATA_IN_ENABLE = 1'b1;
        bus.DATA_IN        = 64'sd99;
        tick();
        tick();
        bus.DATA_IN_ENABLE = 1'b0;
        check_bit("idle_die_doe", bus.DATA_OUT_ENABLE, 1'b0);
        check_bit("idle_die_ready", bus.READY, 1'b1);

        // x = {5,8,8,2}, shift 0 -> {5,3,0,-6}
        start_run(64'd4, 6'd0);
        send(64'sd5, 64'sd5, 1'b0);
        send(64'sd8, 64'sd3, 1'b0);
        send(64'sd8, 64'sd0, 1'b0);
        send(64'sd2, -64'sd6, 1'b1);

        // x = {16,-16,-15}, shift 2 -> {4,-8,0}
        start_run(64'd3, 6'd2);
        send(64'sd16, 64'sd4, 1'b0);
        send(-64'sd16, -64'sd8, 1'b0);
        send(-64'sd15, 64'sd0, 1'b1);

        // Overflowing difference: clamps or wraps depending on the build.
`ifdef MODEL_TRAINER_DIFFERENTIATION_SATURATION_EN
        exp_wrap = MINV;
`else
        exp_wrap = 64'sd1;
`endif
        start_run(64'd2, 6'd0);
        send(MAXV, MAXV, 1'b0);
        send(MINV, exp_wrap, 1'b1);

        // Zero-length start is dropped.
        bus.START   = 1'b1;
        bus.SIZE_IN = 64'd0;
        tick();
        bus.START = 1'b0;
        check_bit("zero_ready", bus.READY, 1'b1);
        check_bit("zero_de", bus.DATA_ENABLE, 1'b0);
        tick();
        check_bit("zero_de2", bus.DATA_ENABLE, 1'b0);
        check_bit("zero_doe2", bus.DATA_OUT_ENABLE, 1'b0);

        // START mid-run does not disturb the run in progress.
        start_run(64'd2, 6'd0);
        bus.START    = 1'b1;
        bus.SIZE_IN  = 64'd9;
        bus.SHIFT_IN = 6'd3;
        tick();
        bus.START = 1'b0;
        check_bit("midstart_ready", bus.READY, 1'b0);
        check_bit("midstart_de", bus.DATA_ENABLE, 1'b0);
        check_bit("midstart_doe", bus.DATA_OUT_ENABLE, 1'b0);
        send(64'sd10, 64'sd10, 1'b0);
        send(64'sd4, -64'sd6, 1'b1);

        // Asynchronous reset after element 1 aborts the run immediately.
        start_run(64'd4, 6'd0);
        send(64'sd1, 64'sd1, 1'b0);
        send(64'sd2, 64'sd1, 1'b0);
        RST = 1'b0;
        #1;
        check_bit("arst_doe", bus.DATA_OUT_ENABLE, 1'b0);
        check_bit("arst_de", bus.DATA_ENABLE, 1'b0);
        check("arst_out", bus.DATA_OUT, 64'sd0);
        check_bit("arst_ready", bus.READY, 1'b1);
        tick();
        RST = 1'b1;
        tick();
        check_bit("post_rst_doe", bus.DATA_OUT_ENABLE, 1'b0);
        check_bit("post_rst_de", bus.DATA_ENABLE, 1'b0);
        check_bit("post_rst_ready", bus.READY, 1'b1);
        start_run(64'd1, 6'd0);
        send(64'sd7, 64'sd7, 1'b1);

        // Withheld data: 5 idle cycles mid-run, then correct results resume.
        start_run(64'd3, 6'd1);
        send(64'sd6, 64'sd3, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_bit("stall_doe", bus.DATA_OUT_ENABLE, 1'b0);
            check_bit("stall_de", bus.DATA_ENABLE, 1'b0);
            check("stall_hold", bus.DATA_OUT, 64'sd3);
        end
        send(64'sd20, 64'sd7, 1'b0);
        send(64'sd3, -64'sd9, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
